trap_sequencer: RTL and testbench
=================================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have no parameters; CSR addresses are fixed: mstatus 12'h300, mepc 12'h341, mcause 12'h342, mtval 12'h343.
REQ-002 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-003 RESET  in  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-004 WB_V  in  1  writeback stage holds a valid instruction.
REQ-005 WB_PC  in  64  PC of the writeback instruction.
REQ-006 TRAP_REQ  in  1  trap (exception/interrupt) raised for the writeback instruction.
REQ-007 TRAP_CAUSE  in  64  mcause value; bit 63 = interrupt.
REQ-008 TRAP_TVAL  in  64  mtval value (faulting address or 0).
REQ-009 MRET  in  1  writeback instruction is MRET.
REQ-010 MTVEC  in  64  current mtvec.
REQ-011 MEPC  in  64  current mepc.
REQ-012 MSTATUS  in  64  current mstatus.
REQ-013 CSR_WE  out  1  CSR write strobe, one write per cycle.
REQ-014 CSR_ADDR  out  12  CSR write address.
REQ-015 CSR_WDATA  out  64  CSR write data.
REQ-016 STALL  out  1  freeze fetch through writeback.
REQ-017 FLUSH  out  1  one-cycle pipeline flush pulse.
REQ-018 PC_REDIRECT  out  1  one-cycle PC load pulse.
REQ-019 REDIRECT_PC  out  64  PC loaded when PC_REDIRECT=1.
REQ-020 BUSY  out  1  FSM not in IDLE.

Function
REQ-021 FSM states SHALL be IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, REDIR; only these six.
REQ-022 Requests SHALL be sampled only in IDLE and only when WB_V=1; TRAP_REQ/MRET in any other state or with WB_V=0 are ignored.
REQ-023 Trap accepted in IDLE -> W_MEPC -> W_MCAUSE -> W_MTVAL -> W_MSTAT -> REDIR -> IDLE, one state per cycle.
REQ-024 MRET accepted in IDLE -> W_MSTAT -> REDIR -> IDLE.
REQ-025 TRAP_REQ and MRET together SHALL take the trap path; MRET is discarded.
REQ-026 On acceptance, WB_PC, TRAP_CAUSE, TRAP_TVAL, MTVEC, MEPC, MSTATUS and trap/mret type SHALL be captured; later states use captured values only.
REQ-027 W_MEPC: CSR_WE=1, addr 12'h341, data = {captured PC[63:1],1'b0}.
REQ-028 W_MCAUSE: CSR_WE=1, addr 12'h342, data = captured cause.
REQ-029 W_MTVAL: CSR_WE=1, addr 12'h343, data = captured tval.
REQ-030 W_MSTAT on trap: addr 12'h300, data = captured mstatus with bit7(MPIE)<=bit3(MIE), bit3<=0, bits12:11(MPP)<=2'b11, all other bits unchanged.
REQ-031 W_MSTAT on MRET: addr 12'h300, data = captured mstatus with bit3<=bit7, bit7<=1, bits12:11<=2'b00, others unchanged.
REQ-032 REDIR: PC_REDIRECT=1, FLUSH=1, CSR_WE=0, one cycle only.
REQ-033 Trap target: if mtvec[1:0]=2'b01 and cause[63]=1, REDIRECT_PC = {mtvec[63:2],2'b00} + (cause[5:0] << 2), modulo 2^64; otherwise {mtvec[63:2],2'b00}.
REQ-034 MRET target: REDIRECT_PC = {captured mepc[63:1],1'b0}.
REQ-035 STALL=1 and BUSY=1 in every non-IDLE state, including REDIR; both 0 in IDLE.
REQ-036 In IDLE, CSR_WE, FLUSH and PC_REDIRECT SHALL be 0; CSR_ADDR, CSR_WDATA and REDIRECT_PC hold the previous value, and are don't-care while their strobe is 0.
REQ-037 Trap latency: acceptance at cycle T -> PC_REDIRECT at T+5, IDLE at T+6, where a new request may be accepted.
REQ-038 MRET latency: acceptance at T -> PC_REDIRECT at T+2, IDLE at T+3.
REQ-039 Exactly four CSR writes per trap and one per MRET, in the order above.

Reset
REQ-040 RESET=1 at a clock edge SHALL force IDLE from any state, abandoning remaining writes and any redirect.
REQ-041 After reset, all outputs SHALL be 0, including CSR_ADDR, CSR_WDATA and REDIRECT_PC, and all captured registers SHALL be 0.
REQ-042 A request asserted in the same cycle as RESET SHALL be ignored.

Verification
REQ-043 Sync exception: WB_V=1, TRAP_REQ=1, PC=0x8000_0104, cause=2, tval=0, mtvec=0x8000_0000, mstatus=0x8 -> writes 341<-0x8000_0104, 342<-2, 343<-0, 300<-0x1880; redirect to 0x8000_0000 at T+5.
REQ-044 Vectored interrupt: mtvec=0x8000_0001, cause=0x8000_0000_0000_0007 -> REDIRECT_PC=0x8000_001C.
REQ-045 MRET: mepc=0x8000_0200, mstatus=0x1880 -> 300<-0x88 at T+1, redirect to 0x8000_0200 at T+2, STALL low at T+3.
REQ-046 Simultaneous TRAP_REQ+MRET -> trap sequence only, four writes, no mepc-based redirect.
REQ-047 RESET asserted during W_MCAUSE -> next cycle IDLE, all outputs 0, no further CSR_WE or PC_REDIRECT.
REQ-048 TRAP_REQ pulsed while BUSY, or with WB_V=0 in IDLE -> ignored, sequence unchanged.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: captures the writeback context on
// acceptance, then emits one CSR write per cycle and finishes with a redirect.
module trap_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WB_V,
    input  logic [63:0] WB_PC,
    input  logic        TRAP_REQ,
    input  logic [63:0] TRAP_CAUSE,
    input  logic [63:0] TRAP_TVAL,
    input  logic        MRET,
    input  logic [63:0] MTVEC,
    input  logic [63:0] MEPC,
    input  logic [63:0] MSTATUS,
    output logic        CSR_WE,
    output logic [11:0] CSR_ADDR,
    output logic [63:0] CSR_WDATA,
    output logic        STALL,
    output logic        FLUSH,
    output logic        PC_REDIRECT,
    output logic [63:0] REDIRECT_PC,
    output logic        BUSY
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    typedef enum logic [2:0] {IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, REDIR} state_e;

    state_e      state_q, state_d;
    logic        is_trap_q, is_trap_d;
    logic [63:0] cause_q, cause_d;
    logic [63:0] tval_q, tval_d;
    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mstatus_q, mstatus_d;
    logic        csr_we_q, csr_we_d;
    logic [11:0] csr_addr_q, csr_addr_d;
    logic [63:0] csr_wdata_q, csr_wdata_d;
    logic        flush_q, flush_d;
    logic        redir_q, redir_d;
    logic [63:0] redir_pc_q, redir_pc_d;
    logic        busy_q, busy_d;

    function automatic logic [63:0] trap_mstatus(input logic [63:0] s);
        logic [63:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [63:0] mret_mstatus(input logic [63:0] s);
        logic [63:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b00;
        return r;
    endfunction

    function automatic logic [63:0] trap_target(input logic [63:0] tvec, input logic [63:0] cause);
        logic [63:0] base;
        base = {tvec[63:2], 2'b00};
        if (tvec[1:0] == 2'b01 && cause[63])
            return base + {56'd0, cause[5:0], 2'b00};
        return base;
    endfunction

    // Outputs are computed for the state being entered so they register alongside it.
    always_comb begin
        state_d     = state_q;
        is_trap_d   = is_trap_q;
        cause_d     = cause_q;
        tval_d      = tval_q;
        mtvec_d     = mtvec_q;
        mepc_d      = mepc_q;
        mstatus_d   = mstatus_q;
        csr_we_d    = 1'b0;
        csr_addr_d  = csr_addr_q;
        csr_wdata_d = csr_wdata_q;
        flush_d     = 1'b0;
        redir_d     = 1'b0;
        redir_pc_d  = redir_pc_q;
        busy_d      = 1'b1;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (WB_V && (TRAP_REQ || MRET)) begin
                    is_trap_d = TRAP_REQ;
                    cause_d   = TRAP_CAUSE;
                    tval_d    = TRAP_TVAL;
                    mtvec_d   = MTVEC;
                    mepc_d    = MEPC & ~64'd1;
                    mstatus_d = MSTATUS;
                    busy_d    = 1'b1;
                    csr_we_d  = 1'b1;
                    if (TRAP_REQ) begin
                        state_d     = W_MEPC;
                        csr_addr_d  = ADDR_MEPC;
                        csr_wdata_d = WB_PC & ~64'd1;
                    end else begin
                        state_d     = W_MSTAT;
                        csr_addr_d  = ADDR_MSTATUS;
                        csr_wdata_d = mret_mstatus(MSTATUS);
                    end
                end
            end
            W_MEPC: begin
                state_d     = W_MCAUSE;
                csr_we_d    = 1'b1;
                csr_addr_d  = ADDR_MCAUSE;
                csr_wdata_d = cause_q;
            end
            W_MCAUSE: begin
                state_d     = W_MTVAL;
                csr_we_d    = 1'b1;
                csr_addr_d  = ADDR_MTVAL;
                csr_wdata_d = tval_q;
            end
            W_MTVAL: begin
                state_d     = W_MSTAT;
                csr_we_d    = 1'b1;
                csr_addr_d  = ADDR_MSTATUS;
                csr_wdata_d = trap_mstatus(mstatus_q);
            end
            W_MSTAT: begin
                state_d    = REDIR;
                redir_d    = 1'b1;
                flush_d    = 1'b1;
                redir_pc_d = is_trap_q ? trap_target(mtvec_q, cause_q) : mepc_q;
            end
            REDIR: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            is_trap_q   <= 1'b0;
            cause_q     <= '0;
            tval_q      <= '0;
            mtvec_q     <= '0;
            mepc_q      <= '0;
            mstatus_q   <= '0;
            csr_we_q    <= 1'b0;
            csr_addr_q  <= '0;
            csr_wdata_q <= '0;
            flush_q     <= 1'b0;
            redir_q     <= 1'b0;
            redir_pc_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_trap_q   <= is_trap_d;
            cause_q     <= cause_d;
            tval_q      <= tval_d;
            mtvec_q     <= mtvec_d;
            mepc_q      <= mepc_d;
            mstatus_q   <= mstatus_d;
            csr_we_q    <= csr_we_d;
            csr_addr_q  <= csr_addr_d;
            csr_wdata_q <= csr_wdata_d;
            flush_q     <= flush_d;
            redir_q     <= redir_d;
            redir_pc_q  <= redir_pc_d;
            busy_q      <= busy_d;
        end
    end

    assign CSR_WE      = csr_we_q;
    assign CSR_ADDR    = csr_addr_q;
    assign CSR_WDATA   = csr_wdata_q;
    assign STALL       = busy_q;
    assign BUSY        = busy_q;
    assign FLUSH       = flush_q;
    assign PC_REDIRECT = redir_q;
    assign REDIRECT_PC = redir_pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: a per-cycle expectation queue built from the trap/MRET
// rules, checked every cycle, plus literal checks on the reference scenarios.
module tb_trap_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, WB_V, TRAP_REQ, MRET;
    logic [63:0] WB_PC, TRAP_CAUSE, TRAP_TVAL, MTVEC, MEPC, MSTATUS;
    logic        CSR_WE, STALL, FLUSH, PC_REDIRECT, BUSY;
    logic [11:0] CSR_ADDR;
    logic [63:0] CSR_WDATA, REDIRECT_PC;

    int checks = 0;
    int errors = 0;

    trap_sequencer dut (
        .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_PC(WB_PC), .TRAP_REQ(TRAP_REQ),
        .TRAP_CAUSE(TRAP_CAUSE), .TRAP_TVAL(TRAP_TVAL), .MRET(MRET), .MTVEC(MTVEC),
        .MEPC(MEPC), .MSTATUS(MSTATUS), .CSR_WE(CSR_WE), .CSR_ADDR(CSR_ADDR),
        .CSR_WDATA(CSR_WDATA), .STALL(STALL), .FLUSH(FLUSH), .PC_REDIRECT(PC_REDIRECT),
        .REDIRECT_PC(REDIRECT_PC), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [63:0] rpc;
    } exp_t;

    exp_t cur;
    exp_t pend[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_trap_status(input logic [63:0] s);
        return (s & ~64'h1888) | (((s >> 3) & 64'd1) << 7) | 64'h1800;
    endfunction

    function automatic logic [63:0] m_mret_status(input logic [63:0] s);
        return (s & ~64'h1888) | (((s >> 7) & 64'd1) << 3) | 64'h80;
    endfunction

    function automatic logic [63:0] m_target(input logic [63:0] tvec, input logic [63:0] cause);
        logic [63:0] base;
        base = tvec - (tvec % 64'd4);
        if ((tvec % 64'd4) == 64'd1 && (cause >> 63) == 64'd1)
            base = base + (cause % 64'd64) * 64'd4;
        return base;
    endfunction

    // Queue the cycle-by-cycle outputs of one accepted request.
    task automatic plan();
        exp_t r;
        r = cur;
        r.stall = 1'b1; r.flush = 1'b0; r.redir = 1'b0; r.we = 1'b1;
        if (TRAP_REQ) begin
            r.addr = 12'h341; r.wdata = WB_PC & ~64'd1;       pend.push_back(r);
            r.addr = 12'h342; r.wdata = TRAP_CAUSE;           pend.push_back(r);
            r.addr = 12'h343; r.wdata = TRAP_TVAL;            pend.push_back(r);
            r.addr = 12'h300; r.wdata = m_trap_status(MSTATUS); pend.push_back(r);
            r.rpc = m_target(MTVEC, TRAP_CAUSE);
        end else begin
            r.addr = 12'h300; r.wdata = m_mret_status(MSTATUS); pend.push_back(r);
            r.rpc = MEPC & ~64'd1;
        end
        r.we = 1'b0; r.redir = 1'b1; r.flush = 1'b1;
        pend.push_back(r);
    endtask

    task automatic compare();
        chk("CSR_WE", {63'd0, CSR_WE}, {63'd0, cur.we});
        chk("STALL", {63'd0, STALL}, {63'd0, cur.stall});
        chk("BUSY", {63'd0, BUSY}, {63'd0, cur.stall});
        chk("FLUSH", {63'd0, FLUSH}, {63'd0, cur.flush});
        chk("PC_REDIRECT", {63'd0, PC_REDIRECT}, {63'd0, cur.redir});
        if (cur.we) begin
            chk("CSR_ADDR", {52'd0, CSR_ADDR}, {52'd0, cur.addr});
            chk("CSR_WDATA", CSR_WDATA, cur.wdata);
        end
        if (cur.redir) chk("REDIRECT_PC", REDIRECT_PC, cur.rpc);
    endtask

    // Inputs are set just after a negedge; this advances one clock and checks.
    task automatic cycle();
        if (RESET) pend.delete();
        else if (pend.size() == 0 && !cur.stall && WB_V && (TRAP_REQ || MRET)) plan();
        @(posedge CLK);
        if (RESET) begin
            cur = '{we: 1'b0, addr: '0, wdata: '0, stall: 1'b0, flush: 1'b0, redir: 1'b0, rpc: '0};
        end else if (pend.size() > 0) begin
            cur = pend.pop_front();
        end else begin
            cur.we = 1'b0; cur.stall = 1'b0; cur.flush = 1'b0; cur.redir = 1'b0;
        end
        @(negedge CLK);
        compare();
    endtask

    task automatic clear_req();
        WB_V = 1'b0; TRAP_REQ = 1'b0; MRET = 1'b0;
    endtask

    initial begin
        cur = '{we: 1'b0, addr: '0, wdata: '0, stall: 1'b0, flush: 1'b0, redir: 1'b0, rpc: '0};
        RESET = 1'b1; clear_req();
        WB_PC = '0; TRAP_CAUSE = '0; TRAP_TVAL = '0; MTVEC = '0; MEPC = '0; MSTATUS = '0;
        cycle(); cycle();
        chk("rst_addr", {52'd0, CSR_ADDR}, 64'd0);
        chk("rst_wdata", CSR_WDATA, 64'd0);
        chk("rst_rpc", REDIRECT_PC, 64'd0);
        chk("rst_busy", {63'd0, BUSY}, 64'd0);

        // Synchronous exception, with an ignored re-request while busy.
        RESET = 1'b0; WB_V = 1'b1; TRAP_REQ = 1'b1; WB_PC = 64'h8000_0104;
        TRAP_CAUSE = 64'd2; TRAP_TVAL = 64'd0; MTVEC = 64'h8000_0000; MSTATUS = 64'h8;
        MEPC = 64'h1234_5678;
        cycle();
        chk("exc_t1_addr", {52'd0, CSR_ADDR}, 64'h341);
        chk("exc_t1_data", CSR_WDATA, 64'h8000_0104);
        TRAP_CAUSE = 64'd5; WB_PC = 64'hdead_0000;
        cycle();
        chk("exc_t2_addr", {52'd0, CSR_ADDR}, 64'h342);
        chk("exc_t2_data", CSR_WDATA, 64'd2);
        clear_req();
        cycle();
        chk("exc_t3_addr", {52'd0, CSR_ADDR}, 64'h343);
        chk("exc_t3_data", CSR_WDATA, 64'd0);
        cycle();
        chk("exc_t4_addr", {52'd0, CSR_ADDR}, 64'h300);
        chk("exc_t4_data", CSR_WDATA, 64'h1880);
        cycle();
        chk("exc_t5_redir", {63'd0, PC_REDIRECT}, 64'd1);
        chk("exc_t5_pc", REDIRECT_PC, 64'h8000_0000);
        cycle();
        chk("exc_t6_stall", {63'd0, STALL}, 64'd0);

        // Request with WB_V low is ignored.
        TRAP_REQ = 1'b1;
        cycle();
        chk("nov_stall", {63'd0, STALL}, 64'd0);
        clear_req();

        // Vectored interrupt.
        WB_V = 1'b1; TRAP_REQ = 1'b1; MTVEC = 64'h8000_0001; TRAP_CAUSE = 64'h8000_0000_0000_0007;
        cycle();
        clear_req();
        repeat (4) cycle();
        chk("vec_redir", {63'd0, PC_REDIRECT}, 64'd1);
        chk("vec_pc", REDIRECT_PC, 64'h8000_001C);
        cycle();

        // MRET.
        WB_V = 1'b1; MRET = 1'b1; MEPC = 64'h8000_0200; MSTATUS = 64'h1880;
        cycle();
        chk("mret_addr", {52'd0, CSR_ADDR}, 64'h300);
        chk("mret_data", CSR_WDATA, 64'h88);
        clear_req();
        cycle();
        chk("mret_pc", REDIRECT_PC, 64'h8000_0200);
        cycle();
        chk("mret_t3_stall", {63'd0, STALL}, 64'd0);

        // TRAP_REQ with MRET takes the trap path.
        WB_V = 1'b1; TRAP_REQ = 1'b1; MRET = 1'b1; MTVEC = 64'h4000_0000; MEPC = 64'h1234_0000;
        TRAP_CAUSE = 64'd11;
        cycle();
        chk("both_addr", {52'd0, CSR_ADDR}, 64'h341);
        clear_req();
        repeat (4) cycle();
        chk("both_pc", REDIRECT_PC, 64'h4000_0000);
        cycle();

        // Reset during W_MCAUSE abandons the sequence.
        WB_V = 1'b1; TRAP_REQ = 1'b1;
        cycle();
        clear_req();
        cycle();
        chk("rmid_addr", {52'd0, CSR_ADDR}, 64'h342);
        RESET = 1'b1;
        cycle();
        chk("rmid_we", {63'd0, CSR_WE}, 64'd0);
        chk("rmid_wdata", CSR_WDATA, 64'd0);
        chk("rmid_stall", {63'd0, STALL}, 64'd0);
        RESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rmid_quiet", {62'd0, CSR_WE, PC_REDIRECT}, 64'd0);
        end

        // Request coinciding with reset is ignored.
        RESET = 1'b1; WB_V = 1'b1; TRAP_REQ = 1'b1;
        cycle();
        RESET = 1'b0; clear_req();
        cycle();
        chk("rreq_stall", {63'd0, STALL}, 64'd0);

        for (int i = 0; i < 3000; i++) begin
            RESET      = ($urandom_range(0, 59) == 0);
            WB_V       = $urandom_range(0, 1) == 1;
            TRAP_REQ   = $urandom_range(0, 3) == 0;
            MRET       = $urandom_range(0, 3) == 0;
            WB_PC      = {$urandom(), $urandom()};
            TRAP_CAUSE = {$urandom(), $urandom()};
            TRAP_TVAL  = {$urandom(), $urandom()};
            MTVEC      = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 1) MTVEC[1:0] = 2'b01;
            MEPC       = {$urandom(), $urandom()};
            MSTATUS    = {$urandom(), $urandom()};
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
